tu_lookup_arbiter: RTL
======================

Name: tu_lookup_arbiter

Overview:
Shares one single-ported TLB lookup/maintenance port between the instruction-fetch requester, the data requester and the TLB-op (CP0) requester. It sits between the fetch/memory pipeline stages and the TLB array, serialising lookups and maintenance ops. It provides fixed, known-latency responses and starvation-free fetch access.

Parameters:
LOOKUP_LAT, 1, cycles from tlb_lk_valid to TLB result valid on tlb_lk_* inputs; legal range 1..4.
STARVE_LIMIT, 3, consecutive d-grants made while i is waiting, after which i beats d; legal range 1..15.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch translation request
i_vaddr  in  32  fetch virtual address
i_req_ready  out  1  fetch request accepted this cycle
i_resp_valid  out  1  one-cycle response pulse
i_paddr  out  32  translated address
i_uncached  out  1  uncached attribute
i_miss  out  1  TLB miss/invalid
d_req_valid  in  1  data translation request
d_vaddr  in  32  data virtual address
d_req_ready  out  1  data request accepted
d_resp_valid  out  1  one-cycle response pulse
d_paddr  out  32  translated address
d_uncached  out  1  uncached attribute
d_miss  out  1  TLB miss/invalid
op_valid  in  1  TLB maintenance request
op_kind  in  2  tu_op_kind_t: TLBR, TLBWI, TLBWR, TLBP
op_ready  out  1  op accepted this cycle
op_done  out  1  one-cycle completion pulse
tlb_lk_valid  out  1  lookup strobe to TLB
tlb_lk_vaddr  out  32  lookup address
tlb_lk_paddr  in  32  TLB result, valid LOOKUP_LAT cycles after strobe
tlb_lk_uncached  in  1  TLB result attribute
tlb_lk_miss  in  1  TLB result miss
tlb_op_valid  out  1  held high until tlb_op_done
tlb_op_kind  out  2  registered op kind
tlb_op_done  in  1  TLB op complete (may arrive in the first cycle tlb_op_valid is high)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - State is IDLE and starve_cnt is 0.
  - All *_ready, *_resp_valid, op_done, tlb_lk_valid and tlb_op_valid are 0.
  - i/d_paddr, i/d_uncached, i/d_miss, tlb_lk_vaddr and tlb_op_kind are 0.
- States: IDLE, LOOKUP, OP_WAIT.
- IDLE, winner selection (combinational), highest priority first:
  - op_valid wins first.
  - i_req_valid wins when starve_cnt==STARVE_LIMIT.
  - Otherwise d_req_valid, then i_req_valid.
  - Exactly one of op_ready/i_req_ready/d_req_ready is high, and only for the winner. All are 0 outside IDLE.
- Lookup grant at cycle T:
  - tlb_lk_valid=1 and tlb_lk_vaddr=winner vaddr in cycle T, combinationally. tlb_lk_valid is 0 outside a grant cycle.
  - Owner is latched and the latency counter is loaded with LOOKUP_LAT; next state is LOOKUP.
- LOOKUP:
  - Counter decrements each cycle.
  - In cycle T+LOOKUP_LAT the TLB result is registered into the owner's paddr/uncached/miss. The owner's resp_valid is high in cycle T+LOOKUP_LAT+1.
  - State returns to IDLE in cycle T+LOOKUP_LAT+1, so a new grant may coincide with resp_valid.
  - Throughput is one lookup per LOOKUP_LAT+1 cycles.
  - The non-owner's response outputs hold their previous value.
- Responses have no back-pressure: requesters must consume the resp_valid pulse.
- Op grant:
  - tlb_op_kind is registered and the next state is OP_WAIT.
  - tlb_op_valid is high from T+1 until, and including, the cycle tlb_op_done=1.
  - op_done pulses the following cycle, together with the return to IDLE.
  - Ops arriving during LOOKUP wait for IDLE. In-flight lookups are never aborted.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) on a d-grant while i_req_valid=1.
  - Clears on an i-grant.
  - Unchanged on op-grants or idle cycles.
- Request stability: requesters hold valid and vaddr stable until ready. The arbiter does not check this.
- Reset mid-LOOKUP or mid-OP_WAIT: the transaction is dropped. No resp_valid/op_done is produced and tlb_op_valid falls the next cycle.

Decomposition:
- Shared tu package holds:
  - tu_op_kind_t (2-bit enum)
  - tu_arb_state_t (IDLE/LOOKUP/OP_WAIT)
  - tu_owner_t (I/D)
  - the 32-bit vaddr/paddr typedefs
- One sub-module, tu_arb_priority: combinational winner select plus the registered starve_cnt. The top level holds the FSM, latency counter and response registers.

Test Plan:
- LOOKUP_LAT=1; i_req_valid with vaddr 0x8000_1000, TLB returns 0x0000_1000 -> i_req_ready at T, tlb_lk_valid at T, i_resp_valid at T+2, i_paddr=0x0000_1000.
- i and d valid together in IDLE, starve_cnt=0 -> d granted first, i granted at T+2; both responses correct; starve_cnt returns to 0.
- d held valid continuously, i valid, STARVE_LIMIT=3 -> grant sequence d,d,d,i; i_resp_valid arrives within 4*(LAT+1)+1 cycles.
- op_valid TLBWI arrives during LOOKUP with tlb_op_done delayed 3 cycles -> lookup response delivered first; op_ready in the return-to-IDLE cycle; tlb_op_valid high 3 cycles; op_done one cycle later.
- op_valid, i and d all valid in IDLE -> op granted first; tlb_lk_valid stays 0 until after op_done.
- reset asserted the cycle after a d grant -> no d_resp_valid; all outputs 0 the next cycle; a fresh request is accepted normally after reset deasserts.

Source files
------------

// File: rtl/tu_lookup_arbiter_pkg.sv
// Shared types for the TLB lookup arbiter: op kinds, arbiter states, lookup owner
// and the address typedefs used on the requester and TLB sides.
package tu_lookup_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } tu_op_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOOKUP  = 2'd1,
    ST_OP_WAIT = 2'd2
  } tu_arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } tu_owner_t;

  typedef logic [31:0] tu_vaddr_t;
  typedef logic [31:0] tu_paddr_t;

endpackage

// File: rtl/tu_arb_priority.sv
// Winner select for the shared TLB port plus the fetch starvation counter that
// lets a waiting fetch request overtake a stream of data requests.
module tu_arb_priority #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic op_valid,
  input  logic i_req_valid,
  input  logic d_req_valid,
  output logic op_grant,
  output logic i_grant,
  output logic d_grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  always_comb begin
    op_grant = 1'b0;
    i_grant  = 1'b0;
    d_grant  = 1'b0;
    if (arb_en) begin
      if (op_valid)                               op_grant = 1'b1;
      else if (i_req_valid && starve_cnt == LIMIT) i_grant  = 1'b1;
      else if (d_req_valid)                       d_grant  = 1'b1;
      else if (i_req_valid)                       i_grant  = 1'b1;
    end
  end

  // Counts d-grants that bypassed a waiting fetch; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (i_grant) begin
      starve_cnt <= 4'd0;
    end else if (d_grant && i_req_valid && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/tu_lookup_arbiter.sv
// Serialises fetch/data lookups and CP0 maintenance ops onto one TLB port with a
// fixed lookup latency and registered, pulse-style responses.
module tu_lookup_arbiter
  import tu_lookup_arbiter_pkg::*;
#(
  parameter int LOOKUP_LAT   = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req_valid,
  input  tu_vaddr_t     i_vaddr,
  output logic          i_req_ready,
  output logic          i_resp_valid,
  output tu_paddr_t     i_paddr,
  output logic          i_uncached,
  output logic          i_miss,
  input  logic          d_req_valid,
  input  tu_vaddr_t     d_vaddr,
  output logic          d_req_ready,
  output logic          d_resp_valid,
  output tu_paddr_t     d_paddr,
  output logic          d_uncached,
  output logic          d_miss,
  input  logic          op_valid,
  input  tu_op_kind_t   op_kind,
  output logic          op_ready,
  output logic          op_done,
  output logic          tlb_lk_valid,
  output tu_vaddr_t     tlb_lk_vaddr,
  input  tu_paddr_t     tlb_lk_paddr,
  input  logic          tlb_lk_uncached,
  input  logic          tlb_lk_miss,
  output logic          tlb_op_valid,
  output tu_op_kind_t   tlb_op_kind,
  input  logic          tlb_op_done,
  output tu_arb_state_t dbg_state
);

  // Handshake: a request is taken in the single cycle where valid && ready;
  // ready is only ever raised in IDLE, for one winner, and responses carry no
  // back-pressure (resp_valid / op_done are one-cycle pulses).

  localparam logic [2:0] LAT_LOAD = 3'(LOOKUP_LAT);

  tu_arb_state_t state, state_nxt;
  tu_owner_t     owner;
  logic [2:0]    lat_cnt;
  logic          arb_en, op_grant, i_grant, d_grant, lk_grant, lk_last;

  assign arb_en = (state == ST_IDLE) && !reset;

  tu_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_priority (
    .clk         (clk),
    .reset       (reset),
    .arb_en      (arb_en),
    .op_valid    (op_valid),
    .i_req_valid (i_req_valid),
    .d_req_valid (d_req_valid),
    .op_grant    (op_grant),
    .i_grant     (i_grant),
    .d_grant     (d_grant)
  );

  assign lk_grant     = i_grant | d_grant;
  assign op_ready     = op_grant;
  assign i_req_ready  = i_grant;
  assign d_req_ready  = d_grant;
  assign tlb_lk_valid = lk_grant;
  assign tlb_lk_vaddr = i_grant ? i_vaddr : (d_grant ? d_vaddr : '0);
  assign tlb_op_valid = (state == ST_OP_WAIT);
  assign lk_last      = (state == ST_LOOKUP) && (lat_cnt == 3'd1);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (op_grant)      state_nxt = ST_OP_WAIT;
        else if (lk_grant) state_nxt = ST_LOOKUP;
      end
      ST_LOOKUP:  if (lk_last)     state_nxt = ST_IDLE;
      ST_OP_WAIT: if (tlb_op_done) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // The result is captured on the last LOOKUP cycle, so resp_valid and the
  // return to IDLE land in the same cycle and a new grant can overlap it.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= OWN_I;
      lat_cnt      <= 3'd0;
      tlb_op_kind  <= OP_TLBR;
      i_resp_valid <= 1'b0;
      i_paddr      <= '0;
      i_uncached   <= 1'b0;
      i_miss       <= 1'b0;
      d_resp_valid <= 1'b0;
      d_paddr      <= '0;
      d_uncached   <= 1'b0;
      d_miss       <= 1'b0;
      op_done      <= 1'b0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      op_done      <= 1'b0;
      if (lk_grant) begin
        owner   <= i_grant ? OWN_I : OWN_D;
        lat_cnt <= LAT_LOAD;
      end
      if (op_grant) tlb_op_kind <= op_kind;
      if (state == ST_LOOKUP && !lk_last) lat_cnt <= lat_cnt - 3'd1;
      if (lk_last) begin
        if (owner == OWN_I) begin
          i_paddr      <= tlb_lk_paddr;
          i_uncached   <= tlb_lk_uncached;
          i_miss       <= tlb_lk_miss;
          i_resp_valid <= 1'b1;
        end else begin
          d_paddr      <= tlb_lk_paddr;
          d_uncached   <= tlb_lk_uncached;
          d_miss       <= tlb_lk_miss;
          d_resp_valid <= 1'b1;
        end
      end
      if (state == ST_OP_WAIT && tlb_op_done) op_done <= 1'b1;
    end
  end

endmodule
